// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 10/5/1 coin payout with per-denomination inventory
// Pays one coin per clock from stock and reports any remainder it cannot cover.
module change_dispenser #(
  parameter int INIT_TEN  = 4,
  parameter int INIT_FIVE = 4,
  parameter int INIT_ONE  = 10,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refund_valid,
  input  logic [5:0]       refund,
  output logic             req_ready,
  input  logic             restock,
  input  logic [CNT_W-1:0] restock_ten,
  input  logic [CNT_W-1:0] restock_five,
  input  logic [CNT_W-1:0] restock_one,
  output logic [5:0]       coin_out,
  output logic             coin_valid,
  output logic             done,
  output logic             short,
  output logic [5:0]       owed,
  output logic [CNT_W-1:0] cnt_ten,
  output logic [CNT_W-1:0] cnt_five,
  output logic [CNT_W-1:0] cnt_one
);

  typedef enum logic [1:0] {IDLE, PAY, DONE} state_t;

  state_t           state, state_nxt;
  logic [5:0]       rem, rem_nxt;
  logic [CNT_W-1:0] ten_nxt, five_nxt, one_nxt;
  logic [5:0]       coin_out_nxt, owed_nxt;
  logic             coin_valid_nxt, done_nxt, short_nxt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      cnt_ten    <= CNT_W'(INIT_TEN);
      cnt_five   <= CNT_W'(INIT_FIVE);
      cnt_one    <= CNT_W'(INIT_ONE);
      coin_out   <= '0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      owed       <= '0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      cnt_ten    <= ten_nxt;
      cnt_five   <= five_nxt;
      cnt_one    <= one_nxt;
      coin_out   <= coin_out_nxt;
      coin_valid <= coin_valid_nxt;
      done       <= done_nxt;
      short      <= short_nxt;
      owed       <= owed_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    ten_nxt        = cnt_ten;
    five_nxt       = cnt_five;
    one_nxt        = cnt_one;
    coin_out_nxt   = '0;
    coin_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    short_nxt      = 1'b0;
    owed_nxt       = '0;
    case (state)
      IDLE: begin
        // Restock and request may coincide; payout then draws on the new stock.
        if (restock) begin
          ten_nxt  = restock_ten;
          five_nxt = restock_five;
          one_nxt  = restock_one;
        end
        if (refund_valid) begin
          rem_nxt   = refund;
          state_nxt = PAY;
        end
      end
      PAY: begin
        if (rem >= 6'd10 && cnt_ten != '0) begin
          coin_out_nxt   = 6'd10;
          coin_valid_nxt = 1'b1;
          rem_nxt        = rem - 6'd10;
          ten_nxt        = cnt_ten - 1'b1;
        end else if (rem >= 6'd5 && cnt_five != '0) begin
          coin_out_nxt   = 6'd5;
          coin_valid_nxt = 1'b1;
          rem_nxt        = rem - 6'd5;
          five_nxt       = cnt_five - 1'b1;
        end else if (rem >= 6'd1 && cnt_one != '0) begin
          coin_out_nxt   = 6'd1;
          coin_valid_nxt = 1'b1;
          rem_nxt        = rem - 6'd1;
          one_nxt        = cnt_one - 1'b1;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          short_nxt = (rem != '0);
          owed_nxt  = rem;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       refund_valid;
  logic [5:0] refund;
  logic       req_ready;
  logic       restock;
  logic [3:0] restock_ten, restock_five, restock_one;
  logic [5:0] coin_out;
  logic       coin_valid;
  logic       done;
  logic       short;
  logic [5:0] owed;
  logic [3:0] cnt_ten, cnt_five, cnt_one;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset),
    .refund_valid(refund_valid), .refund(refund), .req_ready(req_ready),
    .restock(restock), .restock_ten(restock_ten), .restock_five(restock_five),
    .restock_one(restock_one),
    .coin_out(coin_out), .coin_valid(coin_valid), .done(done), .short(short),
    .owed(owed), .cnt_ten(cnt_ten), .cnt_five(cnt_five), .cnt_one(cnt_one)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int t, input int f, input int o);
    check({tag, " cnt_ten"}, int'(cnt_ten), t);
    check({tag, " cnt_five"}, int'(cnt_five), f);
    check({tag, " cnt_one"}, int'(cnt_one), o);
  endtask

  // Accepts a refund, then expects the coins queued in exp_q followed by done.
  task automatic payout(input string tag, input logic [5:0] amt, input logic bogus,
                        input int exp_short, input int exp_owed);
    int n;
    refund       = amt;
    refund_valid = 1'b1;
    tick();
    refund_valid = bogus;
    refund       = 6'd40;
    check({tag, " busy"}, int'(req_ready), 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, " coin_valid"}, int'(coin_valid), 1);
      check({tag, " coin_out"}, int'(coin_out), exp_q[i]);
      check({tag, " no early done"}, int'(done), 0);
    end
    tick();
    check({tag, " done"}, int'(done), 1);
    check({tag, " idle coin"}, int'(coin_valid), 0);
    check({tag, " short"}, int'(short), exp_short);
    check({tag, " owed"}, int'(owed), exp_owed);
    check({tag, " not ready at done"}, int'(req_ready), 0);
    refund_valid = 1'b0;
    tick();
    check({tag, " done drops"}, int'(done), 0);
    check({tag, " ready again"}, int'(req_ready), 1);
    exp_q.delete();
  endtask

  task automatic do_restock(input logic [3:0] t, input logic [3:0] f, input logic [3:0] o);
    restock_ten  = t;
    restock_five = f;
    restock_one  = o;
    restock      = 1'b1;
    tick();
    restock      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; refund_valid = 1'b0; refund = '0; restock = 1'b0;
    restock_ten = '0; restock_five = '0; restock_one = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset req_ready", int'(req_ready), 1);
    check("reset coin_valid", int'(coin_valid), 0);
    check("reset done", int'(done), 0);
    check("reset coin_out", int'(coin_out), 0);
    check_counts("reset", 4, 4, 10);

    exp_q = '{10, 5, 1};
    payout("r16", 6'd16, 1'b0, 0, 0);
    check_counts("r16", 3, 3, 9);

    payout("r0", 6'd0, 1'b0, 0, 0);
    check_counts("r0", 3, 3, 9);

    do_restock(4'd0, 4'd1, 4'd2);
    check_counts("restock1", 0, 1, 2);
    exp_q = '{5, 1, 1};
    payout("r9 short", 6'd9, 1'b0, 1, 2);
    check_counts("r9 short", 0, 0, 0);

    do_restock(4'd0, 4'd0, 4'd15);
    for (int i = 0; i < 12; i++) exp_q.push_back(1);
    payout("r12 ones", 6'd12, 1'b1, 0, 0);
    check_counts("r12 ones", 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ignored req no coin", int'(coin_valid), 0);
      check("ignored req ready", int'(req_ready), 1);
    end

    // Simultaneous restock and request; ten missing after first coin, paid as 5+5.
    restock_ten = 4'd1; restock_five = 4'd2; restock_one = 4'd0;
    restock = 1'b1;
    exp_q = '{10, 5, 5};
    fork
      begin tick(); restock = 1'b0; end
    join_none
    payout("r20 restock", 6'd20, 1'b0, 0, 0);
    check_counts("r20 restock", 0, 0, 0);

    reset = 1'b1; tick(); reset = 1'b0;
    check_counts("refill", 4, 4, 10);
    refund = 6'd30; refund_valid = 1'b1;
    tick();
    refund_valid = 1'b0;
    tick();
    check("r30 coin1", int'(coin_out), 10);
    tick();
    check("r30 coin2", int'(coin_out), 10);
    check_counts("r30 mid", 2, 4, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort coin_valid", int'(coin_valid), 0);
    check("abort done", int'(done), 0);
    check("abort ready", int'(req_ready), 1);
    check_counts("abort", 4, 4, 10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no coin", int'(coin_valid), 0);
      check("abort no done", int'(done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
